tmr_core: RTL and testbench
===========================

Name: tmr_core

Overview:
- Microsecond timer engine; implements the timer end of the timer interface.
- Driven by a controller (FSM or register block) through enable/mode/time_count/clear; returns a done pulse.
- Derives a 1 µs tick from clk with an internal prescaler.
- Counts 1 to 16,777,215 µs, which covers the 10 s requirement.

Parameters:
- CLK_PER_US, 50, clk cycles per microsecond (50 MHz system clock); legal range ≥1.
- CNT_W, 24, width of time_count and of the internal down-counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  level; high starts/keeps the timer running.
- mode  input  1  0 one-shot, 1 auto-reload; sampled at start.
- time_count  input  CNT_W  period in µs; sampled at start.
- clear  input  1  synchronous abort/clear, highest priority after reset.
- done  output  1  one-cycle pulse on each expiry.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; done=0; prescaler=0; down-counter=0; latched period=0; latched mode=0.
- Priority at each edge: reset > clear > enable/expiry logic.
- States: IDLE, RUNNING, EXPIRED.
- IDLE:
  - enable=1 and clear=0 → RUNNING.
  - Latch period=time_count (value 0 is treated as 1) and mode.
  - Load down-counter with the period; prescaler=0.
- RUNNING:
  - Prescaler counts 0..CLK_PER_US-1 and wraps to 0.
  - us_tick asserts when prescaler==CLK_PER_US-1.
  - Each us_tick decrements the down-counter.
  - On the us_tick where the down-counter==1 (expiry edge): done=1 for exactly the following cycle.
    - mode=1: reload down-counter from the latched period, stay RUNNING, prescaler wraps seamlessly (no lost cycle).
    - mode=0: go to EXPIRED.
- Latency: start sampled at edge E0 → done high in the cycle after edge E0+N·CLK_PER_US (N = latched period). In auto-reload, subsequent pulses follow every N·CLK_PER_US cycles.
- EXPIRED: prescaler and counter idle; done=0. enable=0 → IDLE. Remaining high never retriggers.
- enable=0 while RUNNING: abort to IDLE, no done, prescaler and counter cleared. If this coincides with an expiry edge, done still pulses (the expiry completed first).
- clear=1 in any state:
  - Next state IDLE; prescaler and counter cleared.
  - done=0 next cycle, even if the same edge was an expiry edge.
- clear and enable both high: clear wins; timer restarts on the first edge with clear=0 and enable=1.
- time_count or mode changes while RUNNING: ignored until the next start.
- CLK_PER_US=1: us_tick every RUNNING cycle; done after exactly N cycles.
- Max period 16,777,215: no wrap. The counter only decrements from the loaded value down to 1.
- rst_n low mid-count: identical to reset; no done.

Optional Feature:
- Macro: TMR_STATUS_EN.
- Defined: adds outputs busy (1, high in RUNNING) and remaining_us (CNT_W, current down-counter value).
  - Both registered, reset to 0.
  - remaining_us is 0 in IDLE and EXPIRED.
  - In auto-reload, remaining_us shows the reloaded period right after expiry.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- CLK_PER_US=4, mode=0, time_count=3, enable held high → done high exactly once, in the cycle after edge E0+12; state EXPIRED; no further pulses while enable stays high. Dropping enable then raising it gives a second pulse 12 cycles later.
- CLK_PER_US=4, mode=1, time_count=2 → done pulses at E0+8, +16, +24; each pulse is exactly 1 cycle wide. Changing time_count to 5 mid-run has no effect on the period.
- CLK_PER_US=4, mode=0, time_count=5, clear=1 for one cycle at E0+10 → no done ever. Restart with time_count=1 → done at 4 cycles after restart.
- Expiry collision, CLK_PER_US=2, time_count=1:
  - clear=1 on the expiry edge → done stays 0.
  - enable=0 on the expiry edge (separate run) → done pulses once, then IDLE.
- time_count=0, CLK_PER_US=3, mode=0 → behaves as 1: done after 3 cycles. rst_n=0 at E0+2 of a time_count=4 run → done=0, IDLE, no pulse.
- With TMR_STATUS_EN defined, CLK_PER_US=2, time_count=3:
  - remaining_us reads 3, 3, 2, 2, 1, 1 across cycles.
  - busy=1 throughout the run; both outputs are 0 after expiry in one-shot.

Source files
------------

// File: rtl/tmr_if.sv
// Controller-to-timer interface for tmr_core: start/mode/period/abort in, done pulse out.
// Optional status signals (busy, remaining_us) exist only when TMR_STATUS_EN is defined.
interface tmr_if #(
    parameter int CNT_W = 24
);
    logic             enable;
    logic             mode;
    logic [CNT_W-1:0] time_count;
    logic             clear;
    logic             done;
`ifdef TMR_STATUS_EN
    logic             busy;
    logic [CNT_W-1:0] remaining_us;
`endif

    modport master (
        output enable,
        output mode,
        output time_count,
        output clear,
        input  done
`ifdef TMR_STATUS_EN
        ,
        input  busy,
        input  remaining_us
`endif
    );

    modport slave (
        input  enable,
        input  mode,
        input  time_count,
        input  clear,
        output done
`ifdef TMR_STATUS_EN
        ,
        output busy,
        output remaining_us
`endif
    );
endinterface

// File: rtl/tmr_core.sv
// Microsecond timer engine: prescaler derives a 1 us tick, a down-counter times the period.
// Optional macro TMR_STATUS_EN adds registered busy / remaining_us status outputs.
module tmr_core #(
    parameter int CLK_PER_US = 50,
    parameter int CNT_W      = 24
) (
    input logic  clk,
    input logic  rst_n,
    tmr_if.slave bus
);
    localparam int               PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] start_period;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             us_tick;
    logic             expiry;
`ifdef TMR_STATUS_EN
    logic             busy_q;
    logic [CNT_W-1:0] rem_q;
`endif

    // A requested period of 0 runs as 1 us so the counter never has to wrap.
    always_comb begin
        start_period = (bus.time_count == '0) ? CNT_ONE : bus.time_count;
        us_tick      = (state_q == RUNNING) && (pre_q == PRE_MAX);
        expiry       = us_tick && (cnt_q == CNT_ONE);
    end

    // NOTE: reset is synchronous (sampled on the clock edge), and all state uses <= so every
    // flop samples the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: defaulting state_d to state_q before the case keeps this purely combinational;
    // any path that skipped an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bus.enable) state_d = RUNNING;
                RUNNING: begin
                    if (!bus.enable)           state_d = IDLE;
                    else if (expiry && !mode_q) state_d = EXPIRED;
                end
                EXPIRED: if (!bus.enable) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: prescaler, down-counter, latched period/mode, done pulse.
    always_comb begin
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (bus.clear) begin
            pre_d = '0;
            cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        period_d = start_period;
                        mode_d   = bus.mode;
                        cnt_d    = start_period;
                        pre_d    = '0;
                    end
                end
                RUNNING: begin
                    // An expiry on the same edge as enable dropping has already completed.
                    done_d = expiry;
                    if (!bus.enable || (expiry && !mode_q)) begin
                        pre_d = '0;
                        cnt_d = '0;
                    end else if (us_tick) begin
                        pre_d = '0;
                        cnt_d = expiry ? period_q : (cnt_q - CNT_ONE);
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                EXPIRED: begin
                    pre_d = '0;
                    cnt_d = '0;
                end
                default: begin
                    pre_d = '0;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

`ifdef TMR_STATUS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            rem_q  <= '0;
        end else begin
            busy_q <= (state_d == RUNNING);
            rem_q  <= cnt_d;
        end
    end
`endif

    always_comb begin
        bus.done = done_q;
`ifdef TMR_STATUS_EN
        bus.busy         = busy_q;
        bus.remaining_us = rem_q;
`endif
    end
endmodule

// File: tb/tb_tmr_core.sv
// Directed bench for tmr_core: four instances (CLK_PER_US = 1..4) share one stimulus stream,
// each scenario checks the done output of one instance cycle by cycle against a pulse model.
module tb_tmr_core;
    localparam int CNT_W = 24;

    typedef enum int {S_NONE, S_CLEAR, S_EN, S_RST} stop_e;

    typedef struct {
        int               sel;        // CLK_PER_US of the instance under test
        logic             mode;
        logic [CNT_W-1:0] tc;
        bit               do_rst;     // reset before start, else just drop enable one edge
        int               pre_clear;  // edges with clear and enable both high before start
        stop_e            stop_kind;
        int               stop_at;    // edge E0+k where the stop action is applied
        int               win;        // edges observed after E0
        int               first;      // expected first done cycle (k)
        int               per;        // expected pulse spacing, 0 for single pulse
        int               cnt;        // expected number of pulses in the window
    } scen_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             mode;
    logic [CNT_W-1:0] time_count;
    logic             clear;
    logic [4:1]       done_v;
`ifdef TMR_STATUS_EN
    logic             busy2;
    logic [CNT_W-1:0] rem2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tmr_if #(.CNT_W(CNT_W)) bus ();
        assign bus.enable     = enable;
        assign bus.mode       = mode;
        assign bus.time_count = time_count;
        assign bus.clear      = clear;
        assign done_v[g+1]    = bus.done;
`ifdef TMR_STATUS_EN
        if (g == 1) begin : g_stat
            assign busy2 = bus.busy;
            assign rem2  = bus.remaining_us;
        end
`endif
        tmr_core #(.CLK_PER_US(g + 1), .CNT_W(CNT_W)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_done(input scen_t s, input int k);
        if (s.cnt == 0 || k < s.first) return 1'b0;
        if (s.per == 0) return (k == s.first);
        return ((k - s.first) % s.per == 0) && ((k - s.first) / s.per < s.cnt);
    endfunction

    task automatic run(input scen_t s, input int idx);
        if (s.do_rst) begin
            rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            for (int i = 1; i <= 4; i++)
                check($sformatf("s%0d reset done clk%0d", idx, i), 32'(done_v[i]), 32'd0);
            rst_n = 1'b1;
        end else begin
            enable = 1'b0; clear = 1'b0;
            @(posedge clk);
            #1;
        end
        enable = 1'b1; mode = s.mode; time_count = s.tc;
        for (int i = 0; i < s.pre_clear; i++) begin
            clear = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("s%0d preclear%0d done", idx, i), 32'(done_v[s.sel]), 32'd0);
        end
        clear = 1'b0;
        @(posedge clk);  // E0: start sampled
        #1;
        for (int k = 1; k <= s.win; k++) begin
            time_count = (s.tc == 24'd5) ? 24'd7 : 24'd5;
            mode       = ~s.mode;
            clear      = 1'b0;
            rst_n      = 1'b1;
            if (s.stop_kind != S_NONE && k >= s.stop_at) enable = 1'b0;
            if (k == s.stop_at) begin
                if (s.stop_kind == S_CLEAR) clear = 1'b1;
                if (s.stop_kind == S_RST)   rst_n = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("s%0d done k=%0d", idx, k), 32'(done_v[s.sel]), 32'(exp_done(s, k)));
        end
        rst_n = 1'b1;
        clear = 1'b0;
    endtask

    scen_t tbl[13];

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; time_count = '0; clear = 1'b0;
        tbl = '{
            '{4, 1'b0, 24'd3, 1'b1, 0, S_NONE,   0, 40, 12, 0, 1},  // one-shot, enable held
            '{4, 1'b0, 24'd3, 1'b0, 0, S_NONE,   0, 20, 12, 0, 1},  // drop and re-raise enable
            '{4, 1'b1, 24'd2, 1'b1, 0, S_NONE,   0, 30,  8, 8, 3},  // auto-reload, tc change ignored
            '{4, 1'b0, 24'd5, 1'b1, 0, S_CLEAR, 10, 40,  0, 0, 0},  // clear mid-run
            '{4, 1'b0, 24'd1, 1'b0, 0, S_NONE,   0, 10,  4, 0, 1},  // restart after clear
            '{2, 1'b0, 24'd1, 1'b1, 0, S_CLEAR,  2, 10,  0, 0, 0},  // clear on expiry edge
            '{2, 1'b0, 24'd1, 1'b1, 0, S_EN,     2, 10,  2, 0, 1},  // enable low on expiry edge
            '{3, 1'b0, 24'd0, 1'b1, 0, S_NONE,   0, 10,  3, 0, 1},  // period 0 runs as 1
            '{4, 1'b0, 24'd4, 1'b1, 0, S_RST,    2, 30,  0, 0, 0},  // reset mid-count
            '{1, 1'b0, 24'd5, 1'b1, 0, S_NONE,   0, 10,  5, 0, 1},  // CLK_PER_US=1
            '{1, 1'b1, 24'd3, 1'b1, 0, S_NONE,   0, 10,  3, 3, 3},  // CLK_PER_US=1 reload
            '{2, 1'b1, 24'd3, 1'b1, 0, S_EN,    12, 20,  6, 6, 2},  // reload, enable low at expiry
            '{4, 1'b0, 24'd2, 1'b1, 3, S_NONE,   0, 16,  8, 0, 1}   // clear+enable, then start
        };
        for (int i = 0; i < 13; i++) run(tbl[i], i);

`ifdef TMR_STATUS_EN
        begin
            int exp_rem[7];
            exp_rem = '{3, 3, 2, 2, 1, 1, 0};
            rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("status reset busy", 32'(busy2), 32'd0);
            check("status reset rem", 32'(rem2), 32'd0);
            rst_n = 1'b1; enable = 1'b1; mode = 1'b0; time_count = 24'd3;
            @(posedge clk);
            #1;
            for (int k = 0; k <= 6; k++) begin
                check($sformatf("status rem k=%0d", k), 32'(rem2), 32'(exp_rem[k]));
                check($sformatf("status busy k=%0d", k), 32'(busy2), 32'(k < 6));
                if (k < 6) begin
                    time_count = 24'd9;
                    @(posedge clk);
                    #1;
                end
            end
            check("status done at expiry", 32'(done_v[2]), 32'd1);
            enable = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
